// File: rtl/bsg_fpu_encoder.sv
// ============================================================================
// Module   : bsg_fpu_encoder
// Purpose  : Packs an unpacked fp value into IEEE 754 binary format with
//            serial denormalization, round-to-nearest-even and overflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bsg_fpu_encoder #(
    parameter int e_p = 8,
    parameter int m_p = 23
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,

    input  logic                 v_i,
    output logic                 ready_o,
    input  logic                 sign_i,
    input  logic [e_p+1:0]       exp_i,
    input  logic [m_p-1:0]       man_i,
    input  logic                 guard_i,
    input  logic                 sticky_i,
    input  logic                 zero_i,
    input  logic                 nan_i,
    input  logic                 infty_i,

    output logic                 v_o,
    input  logic                 yumi_i,
    output logic [e_p+m_p:0]     z_o,
    output logic                 overflow_o,
    output logic                 underflow_o,
    output logic                 inexact_o
);

    localparam int                 c_cnt_w     = $clog2(m_p + 3);
    localparam logic [e_p+2:0]     c_shift_max = (e_p + 3)'(m_p + 2);
    localparam logic [e_p+2:0]     c_exp_max   = (e_p + 3)'((1 << e_p) - 1);
    localparam logic [e_p+m_p:0]   c_qnan      = {1'b0, {e_p{1'b1}}, 1'b1, {(m_p-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_sign;
    logic [m_p:0]          r_sig;
    logic                  r_g;
    logic                  r_s;
    logic [e_p+1:0]        r_e;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [e_p+m_p:0]      r_z;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  r_inexact;

    logic                  w_exp_pos;
    logic [e_p+2:0]        w_shamt;
    logic [c_cnt_w-1:0]    w_cnt_init;
    logic                  w_inc;
    logic [m_p+1:0]        w_sum;
    logic                  w_is_denorm;
    logic [e_p+2:0]        w_e_rnd;
    logic                  w_ovf;
    logic                  w_lost;

    assign ready_o     = (r_state == IDLE);
    assign v_o         = (r_state == DONE);
    assign z_o         = r_z;
    assign overflow_o  = r_overflow;
    assign underflow_o = r_underflow;
    assign inexact_o   = r_inexact;

    // Shift distance to reach the denormal scale; capped where every bit is gone.
    always_comb begin
        w_exp_pos  = !exp_i[e_p+1] && (exp_i != '0);
        w_shamt    = (e_p + 3)'(1) - {exp_i[e_p+1], exp_i};
        w_cnt_init = (w_shamt > c_shift_max) ? c_cnt_w'(m_p + 2) : w_shamt[c_cnt_w-1:0];
    end

    // Rounding datapath. A normal carry leaves the fraction at zero and bumps
    // the exponent; a denormal carry into the hidden position yields exp field 1.
    always_comb begin
        w_inc       = r_g & (r_s | r_sig[0]);
        w_sum       = {1'b0, r_sig} + {{(m_p+1){1'b0}}, w_inc};
        w_is_denorm = (r_e == '0);
        w_lost      = r_g | r_s;
        if (w_is_denorm) begin
            w_e_rnd = {{(e_p+2){1'b0}}, w_sum[m_p]};
        end else begin
            w_e_rnd = {1'b0, r_e} + {{(e_p+2){1'b0}}, w_sum[m_p+1]};
        end
        w_ovf = (w_e_rnd >= c_exp_max);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state     <= IDLE;
            r_sign      <= 1'b0;
            r_sig       <= '0;
            r_g         <= 1'b0;
            r_s         <= 1'b0;
            r_e         <= '0;
            r_cnt       <= '0;
            r_z         <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_inexact   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (v_i) begin
                        r_sign      <= sign_i;
                        r_overflow  <= 1'b0;
                        r_underflow <= 1'b0;
                        r_inexact   <= 1'b0;
                        if (nan_i) begin
                            r_z     <= c_qnan;
                            r_state <= DONE;
                        end else if (infty_i) begin
                            r_z     <= {sign_i, {e_p{1'b1}}, {m_p{1'b0}}};
                            r_state <= DONE;
                        end else if (zero_i) begin
                            r_z     <= {sign_i, {(e_p+m_p){1'b0}}};
                            r_state <= DONE;
                        end else if (w_exp_pos) begin
                            r_sig   <= {1'b1, man_i};
                            r_g     <= guard_i;
                            r_s     <= sticky_i;
                            r_e     <= exp_i;
                            r_state <= ROUND;
                        end else begin
                            r_sig   <= {1'b1, man_i};
                            r_g     <= guard_i;
                            r_s     <= sticky_i;
                            r_e     <= '0;
                            r_cnt   <= w_cnt_init;
                            r_state <= SHIFT;
                        end
                    end
                end

                SHIFT: begin
                    r_s   <= r_s | r_g;
                    r_g   <= r_sig[0];
                    r_sig <= r_sig >> 1;
                    r_cnt <= r_cnt - c_cnt_w'(1);
                    if (r_cnt == c_cnt_w'(1)) begin
                        r_state <= ROUND;
                    end
                end

                ROUND: begin
                    if (w_ovf) begin
                        r_z <= {r_sign, {e_p{1'b1}}, {m_p{1'b0}}};
                    end else begin
                        r_z <= {r_sign, w_e_rnd[e_p-1:0], w_sum[m_p-1:0]};
                    end
                    r_overflow  <= w_ovf;
                    r_inexact   <= w_ovf | w_lost;
                    r_underflow <= w_is_denorm & w_lost;
                    r_state     <= DONE;
                end

                DONE: begin
                    if (yumi_i) begin
                        r_state <= IDLE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bsg_fpu_encoder.sv
// ============================================================================
// Module   : tb_bsg_fpu_encoder
// Purpose  : Directed self-checking bench for bsg_fpu_encoder (binary32).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bsg_fpu_encoder;

    logic        clk;
    logic        reset_n;
    logic        v_i;
    logic        ready_o;
    logic        sign_i;
    logic [9:0]  exp_i;
    logic [22:0] man_i;
    logic        guard_i;
    logic        sticky_i;
    logic        zero_i;
    logic        nan_i;
    logic        infty_i;
    logic        v_o;
    logic        yumi_i;
    logic [31:0] z_o;
    logic        overflow_o;
    logic        underflow_o;
    logic        inexact_o;

    int compared;
    int mismatched;

    bsg_fpu_encoder #(.e_p(8), .m_p(23)) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .v_i         (v_i),
        .ready_o     (ready_o),
        .sign_i      (sign_i),
        .exp_i       (exp_i),
        .man_i       (man_i),
        .guard_i     (guard_i),
        .sticky_i    (sticky_i),
        .zero_i      (zero_i),
        .nan_i       (nan_i),
        .infty_i     (infty_i),
        .v_o         (v_o),
        .yumi_i      (yumi_i),
        .z_o         (z_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o),
        .inexact_o   (inexact_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic s, input int e, input logic [22:0] m,
                            input logic g, input logic st,
                            input logic zr, input logic nn, input logic inf);
        @(negedge clk);
        chk("ready_before_accept", {31'b0, ready_o}, 32'd1);
        sign_i   = s;
        exp_i    = 10'(e);
        man_i    = m;
        guard_i  = g;
        sticky_i = st;
        zero_i   = zr;
        nan_i    = nn;
        infty_i  = inf;
        v_i      = 1'b1;
        @(posedge clk);
        #1;
        v_i = 1'b0;
    endtask

    // Waits for v_o counting cycles from the accept cycle, then checks result.
    task automatic finish_op(input string tag, input int exp_lat, input logic [31:0] exp_z,
                             input logic ovf, input logic unf, input logic inx);
        int lat;
        lat = 1;
        while (!v_o && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_v"},   {31'b0, v_o}, 32'd1);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_z"},   z_o, exp_z);
        chk({tag, "_flags"}, {29'b0, overflow_o, underflow_o, inexact_o}, {29'b0, ovf, unf, inx});
    endtask

    task automatic take;
        @(negedge clk);
        yumi_i = 1'b1;
        @(posedge clk);
        #1;
        yumi_i = 1'b0;
        chk("ready_after_yumi", {31'b0, ready_o}, 32'd1);
        chk("v_after_yumi", {31'b0, v_o}, 32'd0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset_n  = 1'b0;
        v_i      = 1'b0;
        sign_i   = 1'b0;
        exp_i    = '0;
        man_i    = '0;
        guard_i  = 1'b0;
        sticky_i = 1'b0;
        zero_i   = 1'b0;
        nan_i    = 1'b0;
        infty_i  = 1'b0;
        yumi_i   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_v", {31'b0, v_o}, 32'd0);
        chk("reset_z", z_o, 32'h0);
        chk("reset_flags", {29'b0, overflow_o, underflow_o, inexact_o}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_release", {31'b0, ready_o}, 32'd1);

        // 1.0, plus a 5-cycle hold with yumi low
        start_op(1'b0, 127, 23'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        finish_op("one", 2, 32'h3F800000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold_z", z_o, 32'h3F800000);
            chk("hold_ready", {31'b0, ready_o}, 32'd0);
            chk("hold_v", {31'b0, v_o}, 32'd1);
        end
        take();

        start_op(1'b0, 127, 23'h7FFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        finish_op("carry", 2, 32'h40000000, 1'b0, 1'b0, 1'b1);
        take();

        start_op(1'b0, 254, 23'h7FFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        finish_op("ovf", 2, 32'h7F800000, 1'b1, 1'b0, 1'b1);
        take();

        start_op(1'b0, -3, 23'h300000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        finish_op("denorm", 6, 32'h000B0000, 1'b0, 1'b0, 1'b0);
        take();

        start_op(1'b0, -200, 23'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        finish_op("deep", 27, 32'h00000000, 1'b0, 1'b1, 1'b1);
        take();

        start_op(1'b1, 5, 23'h123, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        finish_op("nan", 1, 32'h7FC00000, 1'b0, 1'b0, 1'b0);
        take();

        start_op(1'b1, 5, 23'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        finish_op("inf", 1, 32'hFF800000, 1'b0, 1'b0, 1'b0);
        take();

        start_op(1'b1, 0, 23'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        finish_op("zero", 1, 32'h80000000, 1'b0, 1'b0, 1'b0);
        take();

        // ties: even stays, odd rounds up
        start_op(1'b0, 127, 23'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        finish_op("tie_even", 2, 32'h3F800000, 1'b0, 1'b0, 1'b1);
        take();

        start_op(1'b0, 127, 23'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        finish_op("tie_odd", 2, 32'h3F800002, 1'b0, 1'b0, 1'b1);
        take();

        start_op(1'b0, 0, 23'h7FFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        finish_op("to_min_normal", 3, 32'h00800000, 1'b0, 1'b1, 1'b1);
        take();

        start_op(1'b0, 1, 23'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        finish_op("min_normal", 2, 32'h00800000, 1'b0, 1'b0, 1'b0);
        take();

        start_op(1'b1, 128, 23'h400000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        finish_op("neg_three", 2, 32'hC0400000, 1'b0, 1'b0, 1'b0);
        take();

        // asynchronous reset in the middle of a long shift
        start_op(1'b0, -200, 23'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_v", {31'b0, v_o}, 32'd0);
        chk("rst_mid_ready", {31'b0, ready_o}, 32'd1);
        chk("rst_mid_z", z_o, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_rel_ready", {31'b0, ready_o}, 32'd1);
        chk("rst_rel_v", {31'b0, v_o}, 32'd0);
        start_op(1'b0, 127, 23'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        finish_op("after_rst", 2, 32'h3F800000, 1'b0, 1'b0, 1'b0);
        take();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
